// File: rtl/bcd_pkg.sv
// Segment codes and BCD decode helper for bcd_seg_scanner.
// Codes are active-low {g,f,e,d,c,b,a}.
package bcd_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] bcd_to_seg7(
    input logic [3:0] i_nib
  );
    logic [6:0] w_seg;
    case (i_nib)
      4'd0:    w_seg = SEG_0;
      4'd1:    w_seg = SEG_1;
      4'd2:    w_seg = SEG_2;
      4'd3:    w_seg = SEG_3;
      4'd4:    w_seg = SEG_4;
      4'd5:    w_seg = SEG_5;
      4'd6:    w_seg = SEG_6;
      4'd7:    w_seg = SEG_7;
      4'd8:    w_seg = SEG_8;
      4'd9:    w_seg = SEG_9;
      default: w_seg = SEG_DASH;
    endcase
    return w_seg;
  endfunction

endpackage

// File: rtl/bcd_seg_scanner_if.sv
// Display bus between BCD counter chain / display and the scanner.
// slave = scanner side, master = counter/display side.
interface bcd_seg_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] D;
  logic [6:0]              SEG;
  logic [NUM_DIGITS-1:0]   AN;
  logic                    FRAME;

  modport master (
    output D,
    input  SEG,
    input  AN,
    input  FRAME
  );

  modport slave (
    input  D,
    output SEG,
    output AN,
    output FRAME
  );
endinterface

// File: rtl/bcd_seg_decode.sv
// Combinational nibble to active-low 7-segment code.
// Non-BCD nibbles map to a dash.
module bcd_seg_decode
  import bcd_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = bcd_to_seg7(i_nib);

endmodule

// File: rtl/bcd_seg_scanner.sv
// Frame-coherent multiplexed 7-segment scanner for BCD digits.
// Optional leading-zero blanking: define BCD_SCAN_LZB_EN.
module bcd_seg_scanner
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic               CLK,
  input  logic               RST,
  bcd_seg_scanner_if.slave   bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         r_pre;
  logic [IW-1:0]         r_idx;
  logic [DW-1:0]         r_snap;
  logic                  r_frame;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  logic                  w_wrap;
  logic                  w_capture;
  logic [3:0]            w_nib;
  logic [6:0]            w_seg;
  logic [NUM_DIGITS-1:0] w_an;
  logic                  w_blank;

  assign w_wrap    = (r_pre == PRE_LAST);
  assign w_capture = w_wrap && (r_idx == IDX_LAST);

  // Scan timing: prescaler, digit index, snapshot and frame pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pre   <= '0;
      r_idx   <= '0;
      r_snap  <= '0;
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_capture;
      if (w_wrap) begin
        r_pre <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      if (w_capture) begin
        r_snap <= bus.D;
      end
    end
  end

  // Select the current digit nibble and its anode
  always_comb begin
    w_nib = '0;
    w_an  = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_nib   = r_snap[4*k +: 4];
        w_an[k] = 1'b0;
      end
    end
  end

`ifdef BCD_SCAN_LZB_EN
  logic w_run;

  // Blank digit k>0 when it and all higher digits are zero
  always_comb begin
    w_run   = 1'b1;
    w_blank = 1'b0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_run = w_run & (r_snap[4*k +: 4] == 4'd0);
      if ((r_idx == IW'(k)) && w_run) begin
        w_blank = 1'b1;
      end
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  bcd_seg_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  // Registered drive with a one-cycle dark gap at each slot start
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
    end else if ((r_pre == '0) || w_blank) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
    end else begin
      r_seg <= w_seg;
      r_an  <= w_an;
    end
  end

  assign bus.SEG   = r_seg;
  assign bus.AN    = r_an;
  assign bus.FRAME = r_frame;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Self-checking bench for bcd_seg_scanner (NUM_DIGITS=4, REFRESH_DIV=4).
// Reference model derives outputs from the cycle count since reset.
module tb_bcd_seg_scanner;

  localparam int N = 4;
  localparam int R = 4;
  localparam int F = N * R;

  logic clk = 1'b0;
  logic rst;

  bcd_seg_scanner_if #(.NUM_DIGITS(N)) bus ();

  bcd_seg_scanner #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned m_n;
  logic [15:0] m_snap;
  logic [6:0]  seg_tab [16];

  typedef struct packed {
    logic [15:0]      d;
    logic [3:0][6:0]  seg;
    logic [3:0][3:0]  an;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void model_out(input int unsigned n,
                                    input logic [15:0] s,
                                    output logic [6:0] seg,
                                    output logic [3:0] an);
    int ph;
    int k;
    ph = int'(n % R);
    k  = int'((n / R) % N);
    seg = 7'h7F;
    an  = 4'hF;
    if (ph != 0) begin
`ifdef BCD_SCAN_LZB_EN
      if (k > 0 && (s >> (4 * k)) == 16'd0) begin
        seg = 7'h7F;
        an  = 4'hF;
      end else begin
        seg = seg_tab[s[4*k +: 4]];
        an  = 4'hF & ~(4'd1 << k);
      end
`else
      seg = seg_tab[s[4*k +: 4]];
      an  = 4'hF & ~(4'd1 << k);
`endif
    end
  endfunction

  task automatic step(input logic r, input logic [15:0] d);
    logic [6:0] es;
    logic [3:0] ea;
    logic       ef;
    es = 7'h7F;
    ea = 4'hF;
    ef = 1'b0;
    rst   = r;
    bus.D = d;
    if (!r) model_out(m_n, m_snap, es, ea);
    @(posedge clk);
    #1;
    if (r) begin
      m_n    = 0;
      m_snap = 16'h0000;
      es     = 7'h7F;
      ea     = 4'hF;
      ef     = 1'b0;
    end else begin
      m_n++;
      if (m_n % F == 0) m_snap = d;
      ef = (m_n % F == 0);
    end
    check("model_seg",   32'(bus.SEG),   32'(es));
    check("model_an",    32'(bus.AN),    32'(ea));
    check("model_frame", 32'(bus.FRAME), 32'(ef));
  endtask

  task automatic wait_frame(input logic [15:0] d, output int cnt);
    bit seen;
    seen = 1'b0;
    cnt  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1'b0, d);
      cnt++;
      seen = bus.FRAME;
    end
    check("frame_seen", 32'(seen), 32'd1);
  endtask

  task automatic show_frame(input vec_t v);
    for (int j = 0; j < N; j++) begin
      step(1'b0, v.d);
      check("tbl_gap_an", 32'(bus.AN), 32'hF);
      for (int p = 0; p < R - 1; p++) begin
        step(1'b0, v.d);
        check("tbl_seg", 32'(bus.SEG), 32'(v.seg[j]));
        check("tbl_an",  32'(bus.AN),  32'(v.an[j]));
      end
    end
  endtask

  initial begin
    int cnt;
    logic [15:0] rd;

    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    vecs[0].d   = 16'h1234;
    vecs[0].seg = {7'h79, 7'h24, 7'h30, 7'h19};
    vecs[0].an  = {4'h7, 4'hB, 4'hD, 4'hE};
    vecs[1].d   = 16'h9999;
    vecs[1].seg = {7'h10, 7'h10, 7'h10, 7'h10};
    vecs[1].an  = {4'h7, 4'hB, 4'hD, 4'hE};
`ifdef BCD_SCAN_LZB_EN
    vecs[2].d   = 16'h00AF;
    vecs[2].seg = {7'h7F, 7'h7F, 7'h3F, 7'h3F};
    vecs[2].an  = {4'hF, 4'hF, 4'hD, 4'hE};
    vecs[3].d   = 16'h0000;
    vecs[3].seg = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    vecs[3].an  = {4'hF, 4'hF, 4'hF, 4'hE};
    vecs[4].d   = 16'h0100;
    vecs[4].seg = {7'h7F, 7'h79, 7'h40, 7'h40};
    vecs[4].an  = {4'hF, 4'hB, 4'hD, 4'hE};
`else
    vecs[2].d   = 16'h00AF;
    vecs[2].seg = {7'h40, 7'h40, 7'h3F, 7'h3F};
    vecs[2].an  = {4'h7, 4'hB, 4'hD, 4'hE};
    vecs[3].d   = 16'h0000;
    vecs[3].seg = {7'h40, 7'h40, 7'h40, 7'h40};
    vecs[3].an  = {4'h7, 4'hB, 4'hD, 4'hE};
    vecs[4].d   = 16'h0100;
    vecs[4].seg = {7'h40, 7'h79, 7'h40, 7'h40};
    vecs[4].an  = {4'h7, 4'hB, 4'hD, 4'hE};
`endif

    m_n    = 0;
    m_snap = 16'h0000;
    rst    = 1'b1;
    bus.D  = 16'h1234;

    // reset held three cycles
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h1234);
      check("rst_seg",   32'(bus.SEG),   32'h7F);
      check("rst_an",    32'(bus.AN),    32'hF);
      check("rst_frame", 32'(bus.FRAME), 32'h0);
    end

    // first frame after reset shows zeros; first FRAME after 16 cycles
    step(1'b0, 16'h1234);
    step(1'b0, 16'h1234);
    check("first_frame_seg0", 32'(bus.SEG), 32'h40);
    check("first_frame_an0",  32'(bus.AN),  32'hE);
    wait_frame(16'h1234, cnt);
    check("first_frame_len", 32'(cnt + 2), 32'(F));

    // table-driven frames
    for (int v = 0; v < 5; v++) begin
      wait_frame(vecs[v].d, cnt);
      show_frame(vecs[v]);
    end

    // D changes mid-frame are held off until next capture
    wait_frame(16'h1234, cnt);
    for (int i = 0; i < 6; i++) step(1'b0, 16'h1234);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h9999);
    check("midframe_seg", 32'(bus.SEG), 32'h24);
    check("midframe_an",  32'(bus.AN),  32'hB);
    for (int i = 0; i < 6; i++) step(1'b0, 16'h9999);
    check("midframe_cap", 32'(bus.FRAME), 32'h1);
    step(1'b0, 16'h9999);
    step(1'b0, 16'h9999);
    check("newframe_seg", 32'(bus.SEG), 32'h10);
    check("newframe_an",  32'(bus.AN),  32'hE);

    // reset in slot idx=2 aborts the frame
    wait_frame(16'h5678, cnt);
    for (int i = 0; i < 10; i++) step(1'b0, 16'h5678);
    check("pre_rst_an", 32'(bus.AN), 32'hB);
    step(1'b1, 16'h5678);
    check("midrst_seg", 32'(bus.SEG), 32'h7F);
    check("midrst_an",  32'(bus.AN),  32'hF);
    wait_frame(16'h5678, cnt);
    check("post_rst_frame_len", 32'(cnt), 32'(F));

    // random stimulus against the model
    rd = 16'(Q_RAND());
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) rd = 16'($urandom);
      step($urandom_range(0, 299) == 0, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  function automatic int unsigned Q_RAND();
    return $urandom;
  endfunction

endmodule
